// File: rtl/game_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_flow_ctrl: WELCOME/PLAY/END sequencer, move-tick divider, score/lives |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module game_flow_ctrl #(
  parameter logic [7:0] START_KEY  = 8'h0D,
  parameter int         MOVE_DIV   = 420000,
  parameter int         MOVE_STEP  = 40000,
  parameter int         LEVEL_STEP = 10,
  parameter int         LIVES      = 3,
  parameter int         SCORE_MAX  = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_ascii,
  input  logic       hit,
  input  logic       miss,
  output logic [1:0] state,
  output logic       play_en,
  output logic       play_rst,
  output logic       move_tick,
  output logic [2:0] level,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       gameover
);

  typedef enum logic [1:0] {
    ST_WEL  = 2'd0,
    ST_PLAY = 2'd1,
    ST_END  = 2'd2,
    ST_ILL  = 2'd3
  } state_t;

  // Highest level whose period is still at least two cycles, capped at 7.
  function automatic int max_level_f();
    int l;
    l = 0;
    for (int i = 1; i <= 7; i++) begin
      if ((l == i - 1) && (MOVE_DIV - i * MOVE_STEP >= 2)) l = i;
    end
    return l;
  endfunction

  localparam logic [19:0] c_move_div   = 20'(MOVE_DIV);
  localparam logic [19:0] c_move_step  = 20'(MOVE_STEP);
  localparam logic [2:0]  c_max_level  = 3'(max_level_f());
  localparam logic [3:0]  c_level_last = 4'(LEVEL_STEP - 1);
  localparam logic [1:0]  c_lives      = 2'(LIVES);
  localparam logic [7:0]  c_score_max  = 8'(SCORE_MAX);

  if ((MOVE_DIV < 2) || (MOVE_DIV > (1 << 19)) || (LIVES < 1) || (LIVES > 3) ||
      (LEVEL_STEP < 1) || (LEVEL_STEP > 16) || (SCORE_MAX < 1) || (SCORE_MAX > 255))
  begin : g_param_check
    $error("game_flow_ctrl: parameter out of range");
  end

  function automatic logic [19:0] period_of(input logic [2:0] lvl);
    return c_move_div - 20'(lvl) * c_move_step;
  endfunction

  state_t      state_q,    state_d;
  logic [7:0]  key_prev_q, key_prev_d;
  logic        play_rst_q, play_rst_d;
  logic        tick_q,     tick_d;
  logic [2:0]  level_q,    level_d;
  logic [7:0]  score_q,    score_d;
  logic [1:0]  lives_q,    lives_d;
  logic [18:0] div_q,      div_d;
  logic [3:0]  hit_cnt_q,  hit_cnt_d;
  logic [19:0] period_q,   period_d;

  logic start;
  logic wrap;

  always_comb begin
    start = (key_ascii == START_KEY) && (key_prev_q != START_KEY);
    wrap  = ({1'b0, div_q} == (period_q - 20'd1));

    state_d    = state_q;
    key_prev_d = key_ascii;
    play_rst_d = 1'b0;
    tick_d     = 1'b0;
    level_d    = level_q;
    score_d    = score_q;
    lives_d    = lives_q;
    div_d      = div_q;
    hit_cnt_d  = hit_cnt_q;
    period_d   = period_q;

    case (state_q)
      ST_WEL: begin
        if (start) begin
          state_d    = ST_PLAY;
          play_rst_d = 1'b1;
          score_d    = 8'd0;
          lives_d    = c_lives;
          level_d    = 3'd0;
          hit_cnt_d  = 4'd0;
          div_d      = 19'd0;
          period_d   = c_move_div;
        end
      end

      ST_PLAY: begin
        // Period is resampled from the level held before this cycle's hit.
        if (wrap) begin
          div_d    = 19'd0;
          tick_d   = 1'b1;
          period_d = period_of(level_q);
        end else begin
          div_d = div_q + 19'd1;
        end

        if (hit) begin
          if (score_q < c_score_max) score_d = score_q + 8'd1;
          if (hit_cnt_q == c_level_last) begin
            hit_cnt_d = 4'd0;
            if (level_q < c_max_level) level_d = level_q + 3'd1;
          end else begin
            hit_cnt_d = hit_cnt_q + 4'd1;
          end
        end

        if (miss) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = ST_END;
            tick_d  = 1'b0;
            div_d   = 19'd0;
          end
        end
      end

      ST_END: begin
        if (start) state_d = ST_WEL;
      end

      default: begin
        state_d    = ST_WEL;
        key_prev_d = 8'd0;
        play_rst_d = 1'b1;
        level_d    = 3'd0;
        score_d    = 8'd0;
        lives_d    = c_lives;
        div_d      = 19'd0;
        hit_cnt_d  = 4'd0;
        period_d   = c_move_div;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WEL;
      key_prev_q <= 8'd0;
      play_rst_q <= 1'b1;
      tick_q     <= 1'b0;
      level_q    <= 3'd0;
      score_q    <= 8'd0;
      lives_q    <= c_lives;
      div_q      <= 19'd0;
      hit_cnt_q  <= 4'd0;
      period_q   <= c_move_div;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_prev_d;
      play_rst_q <= play_rst_d;
      tick_q     <= tick_d;
      level_q    <= level_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      div_q      <= div_d;
      hit_cnt_q  <= hit_cnt_d;
      period_q   <= period_d;
    end
  end

  assign state     = state_q;
  assign play_en   = (state_q == ST_PLAY);
  assign gameover  = (state_q == ST_END);
  assign play_rst  = play_rst_q;
  assign move_tick = tick_q;
  assign level     = level_q;
  assign score     = score_q;
  assign lives     = lives_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_game_flow_ctrl: directed stimulus against a cycle-level game model      |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_game_flow_ctrl;
  localparam int MOVE_DIV   = 10;
  localparam int MOVE_STEP  = 2;
  localparam int LEVEL_STEP = 3;
  localparam int LIVES      = 3;
  localparam int SCORE_MAX  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_ascii;
  logic       hit;
  logic       miss;
  logic [1:0] state;
  logic       play_en;
  logic       play_rst;
  logic       move_tick;
  logic [2:0] level;
  logic [7:0] score;
  logic [1:0] lives;
  logic       gameover;

  game_flow_ctrl #(
    .START_KEY  (8'h0D),
    .MOVE_DIV   (MOVE_DIV),
    .MOVE_STEP  (MOVE_STEP),
    .LEVEL_STEP (LEVEL_STEP),
    .LIVES      (LIVES),
    .SCORE_MAX  (SCORE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_ascii (key_ascii),
    .hit       (hit),
    .miss      (miss),
    .state     (state),
    .play_en   (play_en),
    .play_rst  (play_rst),
    .move_tick (move_tick),
    .level     (level),
    .score     (score),
    .lives     (lives),
    .gameover  (gameover)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: 0=welcome, 1=playing, 2=game over; ticks are scheduled by
  // absolute cycle number rather than by a running divider.
  longint cyc = 0;
  longint m_next_tick = 0;
  int m_state, m_level, m_score, m_lives, m_hits, m_key_prev, m_max_level;
  bit m_play_rst, m_tick;

  function automatic int period_for(input int lvl);
    return MOVE_DIV - lvl * MOVE_STEP;
  endfunction

  initial begin
    m_max_level = 0;
    for (int l = 0; l <= 7; l++) if (period_for(l) >= 2) m_max_level = l;
  end

  always @(posedge clk) begin
    bit start;
    cyc++;
    start = (key_ascii == 8'h0D) && (m_key_prev != 8'h0D);
    m_key_prev = int'(key_ascii);
    m_play_rst = 1'b0;
    m_tick = 1'b0;
    if (reset) begin
      m_state = 0; m_play_rst = 1'b1; m_level = 0; m_score = 0;
      m_lives = LIVES; m_hits = 0; m_key_prev = 0;
    end else begin
      case (m_state)
        0: if (start) begin
          m_state = 1; m_play_rst = 1'b1; m_score = 0; m_lives = LIVES;
          m_level = 0; m_hits = 0; m_next_tick = cyc + MOVE_DIV;
        end
        1: begin
          if (cyc == m_next_tick) begin
            m_tick = 1'b1;
            m_next_tick = cyc + period_for(m_level);
          end
          if (hit) begin
            if (m_score < SCORE_MAX) m_score++;
            m_hits++;
            if (m_hits == LEVEL_STEP) begin
              m_hits = 0;
              if (m_level < m_max_level) m_level++;
            end
          end
          if (miss) begin
            m_lives--;
            if (m_lives == 0) begin
              m_state = 2;
              m_tick = 1'b0;
            end
          end
        end
        default: if (start) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state",     32'(state),     32'(m_state));
      cmp("play_en",   32'(play_en),   32'(m_state == 1));
      cmp("gameover",  32'(gameover),  32'(m_state == 2));
      cmp("play_rst",  32'(play_rst),  32'(m_play_rst));
      cmp("move_tick", 32'(move_tick), 32'(m_tick));
      cmp("level",     32'(level),     32'(m_level));
      cmp("score",     32'(score),     32'(m_score));
      cmp("lives",     32'(lives),     32'(m_lives));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output longint at);
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (move_tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_tick timeout actual=no_tick required=tick at %0t", $time);
    end
  endtask

  task automatic pulse_miss();
    miss = 1'b1;
    @(negedge clk);
    miss = 1'b0;
  endtask

  task automatic press_release();
    key_ascii = 8'h0D;
    step(2);
    key_ascii = 8'h00;
    step(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t, ta, tb, last;
    int n;
    reset = 1'b1; key_ascii = 8'h00; hit = 1'b0; miss = 1'b0;
    step(3);
    reset = 1'b0;
    chk_en = 1'b1;
    cmp("rst_state",    32'(state),    32'd0);
    cmp("rst_play_rst", 32'(play_rst), 32'd1);
    cmp("rst_lives",    32'(lives),    32'd3);
    cmp("rst_score",    32'(score),    32'd0);
    step(1);

    // T1: held start key enters PLAY exactly once
    key_ascii = 8'h0D;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (play_rst === 1'b1) n++;
    end
    cmp("t1_play_rst_pulses", 32'(n), 32'd1);
    cmp("t1_state", 32'(state), 32'd1);
    key_ascii = 8'h00; step(2);
    key_ascii = 8'h0D; step(2);
    key_ascii = 8'h00; step(1);
    cmp("t1_repress_state", 32'(state), 32'd1);

    // T2: idle ticks at level 0
    wait_tick(t);
    last = t; n = 0;
    repeat (35) begin
      @(negedge clk);
      if (move_tick === 1'b1) begin
        n++;
        cmp("t2_gap", 32'(cyc - last), 32'd10);
        last = cyc;
      end
    end
    cmp("t2_ticks", 32'(n), 32'd3);
    cmp("t2_play_en", 32'(play_en), 32'd1);

    // T3: level-up shortens the period
    wait_tick(t);
    repeat (3) begin
      hit = 1'b1; @(negedge clk);
      hit = 1'b0; @(negedge clk);
    end
    cmp("t3_score3", 32'(score), 32'd3);
    cmp("t3_level1", 32'(level), 32'd1);
    wait_tick(ta); wait_tick(tb);
    cmp("t3_period_l1", 32'(tb - ta), 32'd8);
    wait_tick(t);
    hit = 1'b1; step(7);
    hit = 1'b0; step(1);
    cmp("t3_score_sat", 32'(score), 32'd5);
    cmp("t3_level3",    32'(level), 32'd3);
    wait_tick(ta); wait_tick(tb);
    cmp("t3_period_l3", 32'(tb - ta), 32'd4);

    // T4: three misses end the game
    wait_tick(t);
    pulse_miss(); cmp("t4_lives2", 32'(lives), 32'd2);
    pulse_miss(); cmp("t4_lives1", 32'(lives), 32'd1);
    pulse_miss(); cmp("t4_lives0", 32'(lives), 32'd0);
    cmp("t4_state_end", 32'(state),    32'd2);
    cmp("t4_gameover",  32'(gameover), 32'd1);
    cmp("t4_play_en",   32'(play_en),  32'd0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (move_tick === 1'b1) n++;
    end
    cmp("t4_no_ticks",  32'(n),     32'd0);
    cmp("t4_score_held", 32'(score), 32'd5);

    // T5: simultaneous hit and final miss
    press_release();
    cmp("t5_wel", 32'(state), 32'd0);
    key_ascii = 8'h0D; step(2);
    key_ascii = 8'h00; step(1);
    cmp("t5_play",  32'(state), 32'd1);
    cmp("t5_score0", 32'(score), 32'd0);
    wait_tick(t);
    pulse_miss(); pulse_miss();
    cmp("t5_lives1", 32'(lives), 32'd1);
    hit = 1'b1; miss = 1'b1; @(negedge clk);
    hit = 1'b0; miss = 1'b0;
    cmp("t5_score1",  32'(score), 32'd1);
    cmp("t5_end",     32'(state), 32'd2);
    hit = 1'b1; @(negedge clk);
    hit = 1'b0; @(negedge clk);
    cmp("t5_hit_ignored", 32'(score), 32'd1);

    // T6: held key from END goes to WEL only; reset mid-PLAY
    key_ascii = 8'h0D; step(10);
    cmp("t6_wel_only", 32'(state), 32'd0);
    key_ascii = 8'h00; step(2);
    key_ascii = 8'h0D; step(2);
    key_ascii = 8'h00; step(1);
    cmp("t6_play",   32'(state), 32'd1);
    cmp("t6_score0", 32'(score), 32'd0);
    cmp("t6_lives3", 32'(lives), 32'd3);
    step(13);
    reset = 1'b1; @(negedge clk);
    reset = 1'b0;
    cmp("t6_rst_state",    32'(state),    32'd0);
    cmp("t6_rst_play_rst", 32'(play_rst), 32'd1);
    n = 0;
    repeat (15) begin
      if (move_tick === 1'b1) n++;
      @(negedge clk);
    end
    cmp("t6_no_ticks", 32'(n), 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
